lzw_string_unwinder: RTL and testbench

Decoder-side reader of the LZW dictionary: accepts one 12-bit code, walks its prefix chain through the prefix-code RAM and append-char RAM, stacks the characters, then streams them out in forward order. It sits between the decoder's code parser and its byte output. It is the read-side counterpart of the encoder's dictionary writer. It never writes either RAM.

---
 rtl/lzw_pkg.sv | 20 ++
 rtl/lzw_char_stack.sv | 70 +++++++
 rtl/lzw_string_unwinder.sv | 188 ++++++++++++++++++
 tb/tb_lzw_string_unwinder.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lzw_pkg.sv
// Shared constants and FSM state type for the LZW string unwinder.
// No ports; imported by lzw_char_stack and lzw_string_unwinder.
package lzw_pkg;

    localparam int unsigned CODE_W = 12;
    localparam int unsigned RAM_DW = 13;
    localparam int unsigned CHAR_W = 8;

    // Codes below this value are single-byte literals with no dictionary entry.
    localparam logic [CODE_W-1:0] FIRST_CODE = 12'h100;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StPop,
        StErr
    } state_e;

endpackage

// File: rtl/lzw_char_stack.sv
// LIFO of CHAR_W-bit characters, 2**STACK_AW deep.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset (empties the stack)
//   clear           synchronous clear
//   push, push_data write one character on top (ignored when full)
//   pop             remove the top character (ignored when empty)
//   top             current top character (registered)
//   count           number of stored characters
//   full, empty     occupancy flags
module lzw_char_stack
    import lzw_pkg::*;
#(
    parameter int unsigned STACK_AW = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                push,
    input  logic [CHAR_W-1:0]   push_data,
    input  logic                pop,
    output logic [CHAR_W-1:0]   top,
    output logic [STACK_AW:0]   count,
    output logic                full,
    output logic                empty
);

    localparam int unsigned DEPTH = 2 ** STACK_AW;
    localparam logic [STACK_AW:0]   CNT_ONE = 1;
    localparam logic [STACK_AW-1:0] IDX_TWO = 2;

    logic [CHAR_W-1:0]   mem [DEPTH];
    logic [STACK_AW:0]   count_q;
    logic [CHAR_W-1:0]   top_q;
    logic                do_push;
    logic                do_pop;
    logic [STACK_AW-1:0] wr_idx;
    logic [STACK_AW-1:0] rd_idx;

    assign full    = count_q[STACK_AW];  // count never exceeds DEPTH
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign wr_idx  = count_q[STACK_AW-1:0];
    // Entry that becomes the top after a pop; garbage when popping the last entry.
    assign rd_idx  = count_q[STACK_AW-1:0] - IDX_TWO;

    // Storage kept free of reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_idx] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            count_q <= '0;
            top_q   <= '0;
        end else if (do_push) begin
            count_q <= count_q + CNT_ONE;
            top_q   <= push_data;
        end else if (do_pop) begin
            count_q <= count_q - CNT_ONE;
            top_q   <= mem[rd_idx];
        end
    end

    assign top   = top_q;
    assign count = count_q;

endmodule

// File: rtl/lzw_string_unwinder.sv
// Expands one LZW code into its byte string by walking the prefix chain in the
// dictionary RAMs, stacking append characters, and streaming them out forward.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   code_in/valid/ready        code to expand (handshake)
//   rd_en, rd_wren, rd_addr    read port to prefix-code and append-char RAMs
//   pc_rd_data, ac_rd_data     RAM read data, valid the cycle after rd_en
//   byte_out/valid/ready/last  output byte stream, last marks end of string
//   first_char                 first byte of the most recent string
//   err_loop                   sticky dictionary corruption flag
module lzw_string_unwinder
    import lzw_pkg::*;
#(
    parameter int unsigned STACK_AW = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CODE_W-1:0] code_in,
    input  logic              code_valid,
    output logic              code_ready,
    output logic              rd_en,
    output logic              rd_wren,
    output logic [CODE_W-1:0] rd_addr,
    input  logic [RAM_DW-1:0] pc_rd_data,
    input  logic [CHAR_W-1:0] ac_rd_data,
    output logic [CHAR_W-1:0] byte_out,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic              byte_last,
    output logic [CHAR_W-1:0] first_char,
    output logic              err_loop
);

    localparam logic [STACK_AW:0] CNT_ONE = 1;

    state_e state_q, state_d;

    logic [CODE_W-1:0] cur_q;
    // The terminating literal of a chain is held here rather than on the stack,
    // so a WAIT cycle that ends the chain needs only one stack push.
    logic [CHAR_W-1:0] lit_q;
    logic              lit_pend_q;
    logic [CHAR_W-1:0] first_char_q;
    // Holds code_ready low for the cycle following reset release.
    logic              started_q;

    logic [CODE_W-1:0] prefix;
    logic              prefix_is_lit;
    logic              code_is_lit;
    logic              accept;
    logic              wait_err;
    logic              handshake;
    logic              unused_pc_msb;

    logic              stk_push;
    logic              stk_pop;
    logic              stk_clear;
    logic [CHAR_W-1:0] stk_top;
    logic [STACK_AW:0] stk_count;
    logic              stk_full;
    logic              stk_empty;

    assign prefix        = pc_rd_data[CODE_W-1:0];
    assign unused_pc_msb = pc_rd_data[RAM_DW-1];
    assign prefix_is_lit = (prefix < FIRST_CODE);
    assign code_is_lit   = (code_in < FIRST_CODE);
    assign accept        = code_valid && code_ready;
    // A prefix must be strictly smaller than its code; otherwise the chain loops.
    assign wait_err      = (prefix >= cur_q) || stk_full;
    assign handshake     = byte_valid && byte_ready;

    lzw_char_stack #(
        .STACK_AW (STACK_AW)
    ) u_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (stk_clear),
        .push      (stk_push),
        .push_data (ac_rd_data),
        .pop       (stk_pop),
        .top       (stk_top),
        .count     (stk_count),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = code_is_lit ? StPop : StIssue;
                end
            end
            StIssue: state_d = StWait;
            StWait: begin
                if (wait_err) begin
                    state_d = StErr;
                end else if (prefix_is_lit) begin
                    state_d = StPop;
                end else begin
                    state_d = StIssue;
                end
            end
            StPop: begin
                if (handshake && byte_last) begin
                    state_d = StIdle;
                end
            end
            StErr:   state_d = StErr;
            default: state_d = StIdle;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_q        <= '0;
            lit_q        <= '0;
            lit_pend_q   <= 1'b0;
            first_char_q <= '0;
            started_q    <= 1'b0;
        end else begin
            started_q <= 1'b1;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        cur_q <= code_in;
                        if (code_is_lit) begin
                            lit_q      <= code_in[CHAR_W-1:0];
                            lit_pend_q <= 1'b1;
                        end
                    end
                end
                StWait: begin
                    if (!wait_err) begin
                        if (prefix_is_lit) begin
                            lit_q      <= prefix[CHAR_W-1:0];
                            lit_pend_q <= 1'b1;
                        end else begin
                            cur_q <= prefix;
                        end
                    end
                end
                StPop: begin
                    if (handshake && lit_pend_q) begin
                        lit_pend_q   <= 1'b0;
                        first_char_q <= lit_q;
                    end
                end
                StErr: lit_pend_q <= 1'b0;
                default: ;
            endcase
        end
    end

    // Outputs
    always_comb begin
        rd_en      = (state_q == StIssue);
        rd_wren    = 1'b0;
        rd_addr    = cur_q;  // held through WAIT; the RAM output mux uses the live address
        code_ready = (state_q == StIdle) && started_q;
        byte_valid = (state_q == StPop);
        byte_out   = '0;
        byte_last  = 1'b0;
        if (state_q == StPop) begin
            byte_out  = lit_pend_q ? lit_q : stk_top;
            byte_last = lit_pend_q ? stk_empty : (stk_count == CNT_ONE);
        end
        err_loop   = (state_q == StErr);
        stk_push   = (state_q == StWait) && !wait_err;
        stk_pop    = (state_q == StPop) && handshake && !lit_pend_q;
        stk_clear  = (state_q == StErr);
    end

    assign first_char = first_char_q;

endmodule

// File: tb/tb_lzw_string_unwinder.sv
// Self-checking bench for lzw_string_unwinder: directed and random codes against
// a dictionary model, with a one-cycle-latency RAM that returns junk off-cycle.
module tb_lzw_string_unwinder;

    logic        clk;
    logic        rst_n;
    logic [11:0] code_in;
    logic        code_valid;
    logic        code_ready;
    logic        rd_en;
    logic        rd_wren;
    logic [11:0] rd_addr;
    logic [12:0] pc_rd_data;
    logic [7:0]  ac_rd_data;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ready;
    logic        byte_last;
    logic [7:0]  first_char;
    logic        err_loop;

    int n_vec = 0;
    int n_err = 0;

    logic [11:0] dict_pfx [4096];
    logic [7:0]  dict_chr [4096];

    logic [7:0]  exp_q[$];
    logic [11:0] chain_q[$];
    bit          exp_err;

    lzw_string_unwinder #(
        .STACK_AW (12)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .code_in    (code_in),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .rd_en      (rd_en),
        .rd_wren    (rd_wren),
        .rd_addr    (rd_addr),
        .pc_rd_data (pc_rd_data),
        .ac_rd_data (ac_rd_data),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .byte_last  (byte_last),
        .first_char (first_char),
        .err_loop   (err_loop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Dictionary RAM: data valid only in the cycle after rd_en; junk otherwise.
    always @(posedge clk) begin
        if (rd_en) begin
            pc_rd_data <= {1'($urandom), dict_pfx[rd_addr]};
            ac_rd_data <= dict_chr[rd_addr];
        end else begin
            pc_rd_data <= 13'($urandom);
            ac_rd_data <= 8'($urandom);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected string: recursive definition unrolled from the code back to its literal.
    function automatic void model(input logic [11:0] code);
        logic [11:0] c;
        logic [11:0] p;
        c = code;
        exp_q.delete();
        chain_q.delete();
        exp_err = 1'b0;
        while (c >= 12'h100 && !exp_err) begin
            chain_q.push_back(c);
            p = dict_pfx[c];
            exp_q.push_front(dict_chr[c]);
            if (p >= c) exp_err = 1'b1;
            else c = p;
        end
        if (!exp_err) exp_q.push_front(c[7:0]);
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_code_ready"}, 32'(code_ready), 0);
        check({tag, "_rd_en"},      32'(rd_en), 0);
        check({tag, "_rd_wren"},    32'(rd_wren), 0);
        check({tag, "_rd_addr"},    32'(rd_addr), 0);
        check({tag, "_byte_valid"}, 32'(byte_valid), 0);
        check({tag, "_byte_last"},  32'(byte_last), 0);
        check({tag, "_byte_out"},   32'(byte_out), 0);
        check({tag, "_first_char"}, 32'(first_char), 0);
        check({tag, "_err_loop"},   32'(err_loop), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        byte_ready = 1'b0;
        code_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 32'(code_ready), 1);
    endtask

    // mode 0: always ready, 1: alternating starting stalled, 2: random
    task automatic run_string(input logic [11:0] code, input int mode);
        int  k;
        int  n;
        int  idx;
        int  err0;
        bit  rdy;
        bit  v;
        model(code);
        k = chain_q.size();
        n = 0;
        while (!code_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("code_ready_before", 32'(code_ready), 1);
        code_in = code;
        code_valid = 1'b1;
        @(negedge clk);
        code_valid = 1'b0;
        code_in = 12'($urandom);
        for (int j = 0; j < k; j++) begin
            check("issue_rd_en", 32'(rd_en), 1);
            check("issue_addr", 32'(rd_addr), 32'(chain_q[j]));
            check("issue_no_byte", 32'(byte_valid), 0);
            @(negedge clk);
            check("wait_rd_en", 32'(rd_en), 0);
            check("wait_addr_hold", 32'(rd_addr), 32'(chain_q[j]));
            check("wait_no_byte", 32'(byte_valid), 0);
            @(negedge clk);
        end
        idx = 0;
        n = 0;
        err0 = n_err;
        while (idx < exp_q.size() && n < 400 && n_err < err0 + 6) begin
            v = byte_valid;
            check("byte_valid", 32'(byte_valid), 1);
            check("byte_out", 32'(byte_out), 32'(exp_q[idx]));
            check("byte_last", 32'(byte_last), 32'(idx == exp_q.size() - 1));
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (n % 2) == 1;
                default: rdy = 1'($urandom);
            endcase
            byte_ready = rdy;
            @(negedge clk);
            if (rdy && v) idx++;
            n++;
        end
        check("bytes_consumed", 32'(idx), 32'(exp_q.size()));
        byte_ready = 1'b0;
        check("done_no_byte", 32'(byte_valid), 0);
        check("done_code_ready", 32'(code_ready), 1);
        check("first_char", 32'(first_char), 32'(exp_q[0]));
        check("no_err", 32'(err_loop), 0);
    endtask

    task automatic run_err(input logic [11:0] code);
        int k;
        model(code);
        k = chain_q.size();
        code_in = code;
        code_valid = 1'b1;
        @(negedge clk);
        code_valid = 1'b0;
        for (int j = 0; j < k; j++) begin
            check("err_pre_flag", 32'(err_loop), 0);
            @(negedge clk);
            check("err_pre_no_byte", 32'(byte_valid), 0);
            @(negedge clk);
        end
        for (int j = 0; j < 8; j++) begin
            check("err_flag", 32'(err_loop), 1);
            check("err_code_ready", 32'(code_ready), 0);
            check("err_no_byte", 32'(byte_valid), 0);
            @(negedge clk);
        end
    endtask

    initial begin
        int n;
        logic [11:0] p;
        logic [11:0] c;
        int lo;

        rst_n = 1'b0;
        code_in = '0;
        code_valid = 1'b0;
        byte_ready = 1'b0;

        for (int i = 0; i < 4096; i++) begin
            dict_pfx[i] = 12'h041;
            dict_chr[i] = 8'($urandom);
        end
        for (int i = 256; i < 512; i++) begin
            lo = (i > 276) ? i - 20 : 0;
            p = 12'($urandom_range(i - 1, lo));
            if (p == 12'h105) p = 12'h041;
            dict_pfx[i] = p;
        end
        dict_pfx[12'h100] = 12'h041; dict_chr[12'h100] = 8'h42;
        dict_pfx[12'h101] = 12'h100; dict_chr[12'h101] = 8'h43;
        dict_pfx[12'h102] = 12'h101; dict_chr[12'h102] = 8'h44;
        dict_pfx[12'h105] = 12'h105;

        do_reset();

        run_string(12'h041, 0);
        run_string(12'h100, 0);
        run_string(12'h102, 0);
        run_string(12'h102, 1);

        for (int i = 0; i < 30; i++) begin
            c = 12'($urandom_range(511, 0));
            if (c == 12'h105) c = 12'h106;
            run_string(c, int'($urandom_range(2, 0)));
        end

        run_err(12'h105);
        do_reset();

        // Reset in the middle of streaming "ABCD".
        check("midpop_ready", 32'(code_ready), 1);
        code_in = 12'h102;
        code_valid = 1'b1;
        @(negedge clk);
        code_valid = 1'b0;
        n = 0;
        while (!byte_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("midpop_latency", 32'(n), 6);
        check("midpop_b0", 32'(byte_out), 32'h41);
        byte_ready = 1'b1;
        @(negedge clk);
        check("midpop_b1", 32'(byte_out), 32'h42);
        @(negedge clk);
        check("midpop_b2", 32'(byte_out), 32'h43);
        rst_n = 1'b0;
        byte_ready = 1'b0;
        @(negedge clk);
        check_reset_outputs("midpop_reset");
        rst_n = 1'b1;
        byte_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check("midpop_no_stale", 32'(byte_valid), 0);
        end
        byte_ready = 1'b0;
        run_string(12'h05A, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
